// File: rtl/cp0_pkg.sv
// cp0_pkg -- shared definitions for the CP0 extension block.
//   Holds the CP0 register addresses, the SR and Cause bit positions, the
//   ExcCode values, and a helper that builds the SR write mask.
//   No ports. Imported by cp0_ext.
package cp0_pkg;

    // CP0 register addresses (the mfc0/mtc0 register number)
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    // SR bit positions
    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LSB = 10;
    localparam int SR_IM_T   = 16;

    // Cause bit positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_TI      = 16;
    localparam int CAUSE_BD      = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Only IE, EXL, IM (one bit per external line) and, with the timer, IM_T
    // are storage; every other SR bit reads 0 and ignores writes.
    function automatic logic [31:0] sr_wmask(input int n_hwint, input logic timer_en);
        logic [31:0] m;
        m          = '0;
        m[SR_IE]   = 1'b1;
        m[SR_EXL]  = 1'b1;
        for (int i = 0; i < n_hwint; i++) begin
            m[SR_IM_LSB + i] = 1'b1;
        end
        m[SR_IM_T] = timer_en;
        return m;
    endfunction

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer -- Count/Compare timer of the CP0 extension.
//   Only instantiated when CP0_EXT_TIMER_EN is defined.
// Ports:
//   clk_i      clock, all state on rising edge
//   rst_i      asynchronous active-high reset
//   cnt_we_i   load Count from wr_data_i this cycle (overrides the increment)
//   cmp_we_i   load Compare from wr_data_i this cycle (also clears TI)
//   wr_data_i  mtc0 write data
//   count_o    current Count
//   compare_o  current Compare
//   ti_o       sticky timer interrupt pending
module cp0_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cnt_we_i,
    input  logic        cmp_we_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = cnt_we_i ? wr_data_i : count_q + 32'd1;
        compare_d = cmp_we_i ? wr_data_i : compare_q;
        ti_d      = ti_q;
        // A Compare of 0 means "timer off", so it never matches.
        if (cmp_we_i) begin
            ti_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// cp0_ext -- CP0 exception/interrupt extension: SR, Cause, EPC, BadVAddr,
//   PRId and (optionally) the Count/Compare timer.
//   Build option: define CP0_EXT_TIMER_EN to include the timer (cp0_timer);
//   without it Count/Compare/TI/IM_T read 0 and timer_irq is tied 0.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   we/wr_addr/wr_data   mtc0 write (dropped in any cycle that takes req)
//   rd_addr/rd_data      mfc0 combinational read
//   pc, bd, exc_code     victim PC, delay-slot flag, nonzero = exception
//   badvaddr_in          faulting address for AdEL/AdES
//   hwint                level-sensitive external interrupt lines
//   eret                 clears EXL on the next edge
//   req                  enter the handler this cycle (combinational)
//   epc_out              EPC, bypassed with the value being written on req
//   timer_irq            TI pending
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int          N_HWINT  = 6,
    parameter logic [31:0] PRID_VAL = 32'h1937_6075
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [4:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    input  logic [31:0]        pc,
    input  logic               bd,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        badvaddr_in,
    input  logic [N_HWINT-1:0] hwint,
    input  logic               eret,
    output logic               req,
    output logic [31:0]        epc_out,
    output logic               timer_irq
);

`ifdef CP0_EXT_TIMER_EN
    localparam logic TIMER_EN = 1'b1;
`else
    localparam logic TIMER_EN = 1'b0;
`endif
    localparam logic [31:0] SR_WMASK = sr_wmask(N_HWINT, TIMER_EN);

    logic [31:0]        sr_q, sr_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        badv_q;
    logic               cause_bd_q;
    logic [4:0]         cause_exc_q;
    logic [N_HWINT-1:0] ip_q;

    logic [31:0] count, compare;
    logic        ti;
    logic        int_req, exc_req, wr_ok;
    logic [31:0] epc_new;
    logic [31:0] cause_rd;

    // reset gates req so a nonzero exc_code cannot request during reset
    assign int_req = !reset && sr_q[SR_IE] && !sr_q[SR_EXL] &&
                     ((|(hwint & sr_q[SR_IM_LSB +: N_HWINT])) || (ti && sr_q[SR_IM_T]));
    assign exc_req = !reset && (exc_code != 5'd0) && !sr_q[SR_EXL];
    assign req     = int_req || exc_req;
    assign epc_new = bd ? pc - 32'd4 : pc;
    assign epc_out = req ? epc_new : epc_q;
    assign wr_ok   = we && !req;

`ifdef CP0_EXT_TIMER_EN
    cp0_timer u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .cnt_we_i  (wr_ok && (wr_addr == ADDR_COUNT)),
        .cmp_we_i  (wr_ok && (wr_addr == ADDR_COMPARE)),
        .wr_data_i (wr_data),
        .count_o   (count),
        .compare_o (compare),
        .ti_o      (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    assign timer_irq = ti;

    // eret is applied after an SR write in the same cycle; req overrides both.
    always_comb begin
        sr_d  = sr_q;
        epc_d = epc_q;
        if (req) begin
            sr_d[SR_EXL] = 1'b1;
            epc_d        = epc_new;
        end else begin
            if (wr_ok && (wr_addr == ADDR_SR)) begin
                sr_d = wr_data & SR_WMASK;
            end
            if (wr_ok && (wr_addr == ADDR_EPC)) begin
                epc_d = wr_data;
            end
            if (eret) begin
                sr_d[SR_EXL] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q        <= '0;
            epc_q       <= '0;
            badv_q      <= '0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= '0;
            ip_q        <= '0;
        end else begin
            sr_q  <= sr_d;
            epc_q <= epc_d;
            ip_q  <= hwint;
            if (req) begin
                cause_bd_q  <= bd;
                // interrupt wins over a simultaneous exception
                cause_exc_q <= int_req ? EXC_INT : exc_code;
                if (!int_req && is_addr_exc(exc_code)) begin
                    badv_q <= badvaddr_in;
                end
            end
        end
    end

    always_comb begin
        cause_rd                                = '0;
        cause_rd[CAUSE_BD]                      = cause_bd_q;
        cause_rd[CAUSE_TI]                      = ti;
        cause_rd[CAUSE_IP_LSB +: N_HWINT]       = ip_q;
        cause_rd[CAUSE_EXC_LSB +: 5]            = cause_exc_q;
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_BADVADDR: rd_data = badv_q;
            ADDR_COUNT:    rd_data = count;
            ADDR_COMPARE:  rd_data = compare;
            ADDR_SR:       rd_data = sr_q;
            ADDR_CAUSE:    rd_data = cause_rd;
            ADDR_EPC:      rd_data = epc_out;
            ADDR_PRID:     rd_data = PRID_VAL;
            default:       rd_data = '0;
        endcase
    end

endmodule
